// File: rtl/detector_jogada_pkg.sv
// Shared types and constants for the switch press detector (detector_jogada_debounce).
// Holds the FSM state encoding, the default parameter values and the one-hot test.
package detector_jogada_pkg;

    localparam int N_CHAVES_PADRAO        = 4;
    localparam int DEBOUNCE_CICLOS_PADRAO = 5;
    localparam int TIMEOUT_CICLOS_PADRAO  = 3000;

    typedef enum logic [2:0] {
        OCIOSO         = 3'd0,
        ESTABILIZA     = 3'd1,
        REGISTRA       = 3'd2,
        INVALIDA       = 3'd3,
        AGUARDA_SOLTAR = 3'd4
    } estado_detector_t;

    // True when exactly one bit is set; callers zero-extend narrower vectors.
    function automatic logic eh_one_hot(input logic [31:0] value);
        return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/detector_jogada_debounce_sync.sv
// Two-flop synchronizer for the raw switch levels, asynchronous active-low reset to 0.
module sincronizador_2ff #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);

    logic [LARGURA-1:0] meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/detector_jogada_debounce.sv
// Synchronizes, debounces and one-hot validates switch presses for the memory game.
// Optional idle timeout is built only when DETECTOR_TIMEOUT_EN is defined.
module detector_jogada_debounce
    import detector_jogada_pkg::*;
#(
    parameter int N_CHAVES        = N_CHAVES_PADRAO,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
    parameter int TIMEOUT_CICLOS  = TIMEOUT_CICLOS_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic [N_CHAVES-1:0] chaves,
    output logic                jogada_feita,
    output logic [N_CHAVES-1:0] jogada,
    output logic                jogada_invalida,
    output logic                timeout,
    output logic [2:0]          db_estado
);

    localparam int MAX_CICLOS = (DEBOUNCE_CICLOS > TIMEOUT_CICLOS) ? DEBOUNCE_CICLOS : TIMEOUT_CICLOS;
    localparam int CNT_W      = $clog2(MAX_CICLOS);
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [N_CHAVES-1:0] s;
    estado_detector_t    estado, estado_prox;
    logic [CNT_W-1:0]    cnt, cnt_prox;
    logic [N_CHAVES-1:0] cap, cap_prox;
    logic [N_CHAVES-1:0] jogada_prox;

    sincronizador_2ff #(
        .LARGURA (N_CHAVES)
    ) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (chaves),
        .q     (s)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
            cnt    <= '0;
            cap    <= '0;
            jogada <= '0;
        end else begin
            estado <= estado_prox;
            cnt    <= cnt_prox;
            cap    <= cap_prox;
            jogada <= jogada_prox;
        end
    end

    // jogada_feita / jogada_invalida are single-cycle Moore pulses with no backpressure:
    // the consumer samples them in the cycle they are high; jogada is updated on the
    // edge that ends the jogada_feita cycle and then holds until the next valid press.
    always_comb begin
        estado_prox     = estado;
        cnt_prox        = cnt;
        cap_prox        = cap;
        jogada_prox     = jogada;
        jogada_feita    = 1'b0;
        jogada_invalida = 1'b0;

        case (estado)
            OCIOSO: begin
                cnt_prox = '0;
                if (s != '0) begin
                    if (habilita) begin
                        estado_prox = ESTABILIZA;
                        cap_prox    = s;
                    end else begin
                        // Press made while disabled is dropped until the keys are released.
                        estado_prox = AGUARDA_SOLTAR;
                    end
                end
            end
            ESTABILIZA: begin
                if (s == '0) begin
                    estado_prox = OCIOSO;
                    cnt_prox    = '0;
                end else if (s != cap) begin
                    cap_prox = s;
                    cnt_prox = '0;
                end else if (cnt == CNT_FIM) begin
                    cnt_prox    = '0;
                    estado_prox = eh_one_hot(32'(cap)) ? REGISTRA : INVALIDA;
                end else begin
                    cnt_prox = cnt + 1'b1;
                end
            end
            REGISTRA: begin
                jogada_feita = 1'b1;
                jogada_prox  = cap;
                cnt_prox     = '0;
                estado_prox  = AGUARDA_SOLTAR;
            end
            INVALIDA: begin
                jogada_invalida = 1'b1;
                cnt_prox        = '0;
                estado_prox     = AGUARDA_SOLTAR;
            end
            AGUARDA_SOLTAR: begin
                if (s != '0) begin
                    cnt_prox = '0;
                end else if (cnt == CNT_FIM) begin
                    cnt_prox    = '0;
                    estado_prox = OCIOSO;
                end else begin
                    cnt_prox = cnt + 1'b1;
                end
            end
            default: begin
                estado_prox = OCIOSO;
                cnt_prox    = '0;
            end
        endcase
    end

    assign db_estado = estado;

`ifdef DETECTOR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TCNT_FIM = CNT_W'(TIMEOUT_CICLOS - 1);

    logic [CNT_W-1:0] tcnt;
    logic             timeout_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tcnt      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (estado == OCIOSO && habilita && s == '0) begin
                if (tcnt == TCNT_FIM) begin
                    tcnt      <= '0;
                    timeout_q <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada_debounce.sv
// Self-checking bench for detector_jogada_debounce: phase table plus multi-cycle sequences.
// Timeout sequence is compiled in only with DETECTOR_TIMEOUT_EN (TIMEOUT_CICLOS=20).
module tb_detector_jogada_debounce;

`ifdef DETECTOR_TIMEOUT_EN
    localparam int TB_TIMEOUT = 20;
`else
    localparam int TB_TIMEOUT = 3000;
`endif
    localparam int N = 4;

    logic         clock;
    logic         reset;
    logic         habilita;
    logic [N-1:0] chaves;
    logic         jogada_feita;
    logic [N-1:0] jogada;
    logic         jogada_invalida;
    logic         timeout;
    logic [2:0]   db_estado;

    detector_jogada_debounce #(
        .N_CHAVES        (N),
        .DEBOUNCE_CICLOS (5),
        .TIMEOUT_CICLOS  (TB_TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .chaves          (chaves),
        .jogada_feita    (jogada_feita),
        .jogada          (jogada),
        .jogada_invalida (jogada_invalida),
        .timeout         (timeout),
        .db_estado       (db_estado)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [N-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int feita_tot = 0;
    int inval_tot = 0;
    int to_tot = 0;
    int ovl_tot = 0;
    bit chk_jogada = 1'b0;

    typedef struct {
        logic         hab;
        logic [N-1:0] chaves;
        int           ciclos;
        int           exp_feita;
        int           exp_inv;
        logic [N-1:0] exp_jogada;
        logic [2:0]   exp_estado;
    } vetor_t;

    vetor_t vet[17];

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // One clock: sample 1 time unit after the rising edge, update pulse tallies and scoreboard.
    task automatic step();
        @(posedge clock);
        #1;
        if (chk_jogada) begin
            chk_jogada = 1'b0;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_pulse: got jogada %0h expected no pulse (t=%0t)", jogada, $time);
            end else begin
                check("sb_jogada", 32'(jogada), 32'(exp_q.pop_front()));
            end
        end
        if (jogada_feita) begin
            feita_tot++;
            chk_jogada = 1'b1;
        end
        if (jogada_invalida) inval_tot++;
        if (timeout) to_tot++;
        if (jogada_feita && jogada_invalida) ovl_tot++;
    endtask

    // Press from idle and check the exact pulse latency (7 edges after first sampling).
    task automatic press_latency(input string nome, input logic [N-1:0] valor);
        int f0;
        habilita = 1'b1;
        chaves   = valor;
        exp_q.push_back(valor);
        f0 = feita_tot;
        repeat (7) step();
        check({nome, "_early"}, 32'(feita_tot - f0), 32'd0);
        step();
        check({nome, "_pulse"}, 32'(jogada_feita), 32'd1);
        step();
        check({nome, "_estado"}, 32'(db_estado), 32'd4);
    endtask

    task automatic release_keys(input string nome);
        chaves = '0;
        repeat (8) step();
        check({nome, "_idle"}, 32'(db_estado), 32'd0);
    endtask

    task automatic run_phase(input int idx, input vetor_t v);
        int f0;
        int i0;
        habilita = v.hab;
        chaves   = v.chaves;
        if (v.exp_feita > 0) exp_q.push_back(v.exp_jogada);
        f0 = feita_tot;
        i0 = inval_tot;
        repeat (v.ciclos) step();
        check($sformatf("vec%0d_feita", idx), 32'(feita_tot - f0), 32'(v.exp_feita));
        check($sformatf("vec%0d_invalida", idx), 32'(inval_tot - i0), 32'(v.exp_inv));
        check($sformatf("vec%0d_jogada", idx), 32'(jogada), 32'(v.exp_jogada));
        check($sformatf("vec%0d_estado", idx), 32'(db_estado), 32'(v.exp_estado));
    endtask

    initial begin
        int f0;
        int t0;

        vet[0]  = '{1'b1, 4'b0001, 10, 1, 0, 4'b0001, 3'd4};
        vet[1]  = '{1'b1, 4'b0000,  8, 0, 0, 4'b0001, 3'd0};
        vet[2]  = '{1'b1, 4'b0110, 10, 0, 1, 4'b0001, 3'd4};
        vet[3]  = '{1'b1, 4'b0000,  8, 0, 0, 4'b0001, 3'd0};
        vet[4]  = '{1'b0, 4'b1000, 10, 0, 0, 4'b0001, 3'd4};
        vet[5]  = '{1'b1, 4'b1000, 10, 0, 0, 4'b0001, 3'd4};
        vet[6]  = '{1'b1, 4'b0000,  8, 0, 0, 4'b0001, 3'd0};
        vet[7]  = '{1'b1, 4'b1000, 10, 1, 0, 4'b1000, 3'd4};
        vet[8]  = '{1'b1, 4'b0000,  8, 0, 0, 4'b1000, 3'd0};
        vet[9]  = '{1'b1, 4'b0010,  3, 0, 0, 4'b1000, 3'd1};
        vet[10] = '{1'b1, 4'b0000, 10, 0, 0, 4'b1000, 3'd0};
        vet[11] = '{1'b1, 4'b0001,  3, 0, 0, 4'b1000, 3'd1};
        vet[12] = '{1'b0, 4'b0001,  7, 1, 0, 4'b0001, 3'd4};
        vet[13] = '{1'b1, 4'b0000,  8, 0, 0, 4'b0001, 3'd0};
        vet[14] = '{1'b1, 4'b0001,  4, 0, 0, 4'b0001, 3'd1};
        vet[15] = '{1'b1, 4'b0100, 10, 1, 0, 4'b0100, 3'd4};
        vet[16] = '{1'b1, 4'b0000,  8, 0, 0, 4'b0100, 3'd0};

        // Reset with a key held: everything cleared, then the held key is a fresh press.
        reset    = 1'b1;
        habilita = 1'b1;
        chaves   = 4'b0100;
        #2 reset = 1'b0;
        step();
        step();
        check("rst_feita", 32'(jogada_feita), 32'd0);
        check("rst_invalida", 32'(jogada_invalida), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_jogada", 32'(jogada), 32'd0);
        check("rst_estado", 32'(db_estado), 32'd0);
        reset = 1'b1;
        press_latency("rst_press", 4'b0100);
        release_keys("rst_release");

        for (int i = 0; i < 17; i++) run_phase(i, vet[i]);

        // Bounce: 0010/0000 every 2 cycles for 12 cycles, then stable 0010.
        habilita = 1'b1;
        f0 = feita_tot;
        for (int i = 0; i < 6; i++) begin
            chaves = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            repeat (2) step();
        end
        check("bounce_quiet", 32'(feita_tot - f0), 32'd0);
        press_latency("bounce", 4'b0010);
        release_keys("bounce_release");

        // Asynchronous reset in the middle of debouncing, key kept held across it.
        chaves = 4'b0001;
        repeat (5) step();
        check("midrst_before", 32'(db_estado), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_estado", 32'(db_estado), 32'd0);
        check("midrst_jogada", 32'(jogada), 32'd0);
        step();
        step();
        reset = 1'b1;
        press_latency("midrst_press", 4'b0001);
        release_keys("midrst_release");

        check("timeout_none_so_far", 32'(to_tot), 32'd0);

`ifdef DETECTOR_TIMEOUT_EN
        #2 reset = 1'b0;
        step();
        reset    = 1'b1;
        habilita = 1'b1;
        chaves   = '0;
        t0 = to_tot;
        repeat (19) step();
        check("to_before_20", 32'(to_tot - t0), 32'd0);
        step();
        check("to_at_20", 32'(timeout), 32'd1);
        repeat (40) step();
        check("to_count_60", 32'(to_tot - t0), 32'd3);
        repeat (10) step();
        chaves = 4'b0001;
        exp_q.push_back(4'b0001);
        repeat (15) step();
        release_keys("to_release");
        check("to_suppressed", 32'(to_tot - t0), 32'd3);
`else
        t0 = to_tot;
        habilita = 1'b1;
        chaves   = '0;
        repeat (30) step();
        check("to_disabled", 32'(to_tot - t0), 32'd0);
`endif

        check("pulse_overlap", 32'(ovl_tot), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
